// File: rtl/processor.sv
// Single-cycle 8-bit processor: 16-bit instructions, eight 8-bit registers,
// byte-wide data memory, HALT latches done until init_n is asserted.
module processor #(
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 256
) (
   input  logic clk,
   input  logic init_n,
   output logic done
);

   localparam int PC_W = $clog2(IMEM_DEPTH);
   localparam int DA_W = $clog2(DMEM_DEPTH);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SHL  = 4'h5;
   localparam logic [3:0] OP_SHR  = 4'h6;
   localparam logic [3:0] OP_PAR  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_BNE  = 4'hC;
   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_ADDI = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Both memories are loaded/inspected hierarchically and never reset.
   logic [15:0] imem [IMEM_DEPTH];
   logic [7:0]  dmem [DMEM_DEPTH];

   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      regs_q [8];
   logic [7:0]      regs_d [8];
   logic            done_q, done_d;

   logic [15:0]     instr;
   logic [3:0]      op;
   logic [2:0]      rd, rs, rt;
   logic [7:0]      imm8;
   logic [5:0]      off6;
   logic [9:0]      addr;
   logic [7:0]      rd_val, rs_val, rt_val;
   logic [DA_W-1:0] dmem_addr;
   logic [7:0]      ld_val;
   logic [PC_W-1:0] pc_inc, br_tgt;
   logic [7:0]      res;
   logic            rf_we;
   logic            dmem_we;

   assign instr = imem[pc_q];
   assign op    = instr[15:12];
   assign rd    = instr[11:9];
   assign rs    = instr[8:6];
   assign rt    = instr[5:3];
   assign imm8  = instr[7:0];
   assign off6  = instr[5:0];
   assign addr  = instr[9:0];

   assign rd_val    = regs_q[rd];
   assign rs_val    = regs_q[rs];
   assign rt_val    = regs_q[rt];
   assign dmem_addr = DA_W'(rs_val);
   assign ld_val    = dmem[dmem_addr];

   assign pc_inc = pc_q + PC_W'(1);
   assign br_tgt = pc_inc + {{(PC_W-6){off6[5]}}, off6};

   always_comb begin
      pc_d    = pc_inc;
      done_d  = done_q;
      regs_d  = regs_q;
      res     = 8'h00;
      rf_we   = 1'b0;
      dmem_we = 1'b0;
      if (done_q) begin
         pc_d = pc_q;
      end else begin
         case (op)
            OP_ADD:  begin res = rs_val + rt_val;          rf_we = 1'b1; end
            OP_SUB:  begin res = rs_val - rt_val;          rf_we = 1'b1; end
            OP_AND:  begin res = rs_val & rt_val;          rf_we = 1'b1; end
            OP_OR:   begin res = rs_val | rt_val;          rf_we = 1'b1; end
            OP_XOR:  begin res = rs_val ^ rt_val;          rf_we = 1'b1; end
            OP_SHL:  begin res = {rs_val[6:0], 1'b0};      rf_we = 1'b1; end
            OP_SHR:  begin res = {1'b0, rs_val[7:1]};      rf_we = 1'b1; end
            OP_PAR:  begin res = {7'b0, ^rs_val};          rf_we = 1'b1; end
            OP_LDI:  begin res = imm8;                     rf_we = 1'b1; end
            OP_LD:   begin res = ld_val;                   rf_we = 1'b1; end
            OP_ADDI: begin res = rd_val + imm8;            rf_we = 1'b1; end
            OP_ST:   dmem_we = 1'b1;
            OP_BEQ:  if (rd_val == rs_val) pc_d = br_tgt;
            OP_BNE:  if (rd_val != rs_val) pc_d = br_tgt;
            OP_JMP:  pc_d = PC_W'(addr);
            OP_HALT: begin pc_d = pc_q; done_d = 1'b1; end
            default: ;
         endcase
      end
      if (rf_we) regs_d[rd] = res;
      // A clock edge during reset must not disturb the retained data memory.
      if (!init_n) dmem_we = 1'b0;
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         pc_q   <= '0;
         done_q <= 1'b0;
         for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
      end else begin
         pc_q   <= pc_d;
         done_q <= done_d;
         for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (dmem_we) dmem[dmem_addr] <= rd_val;
   end

   assign done = done_q;

endmodule

// File: tb/tb_processor.sv
// Scoreboard bench for processor: an instruction-level model predicts final
// registers, data memory and cycle count; a monitor checks them when done rises.
module tb_processor;

   logic clk;
   logic init_n;
   logic done;

   processor #(.IMEM_DEPTH(1024), .DMEM_DEPTH(256)) dut (
      .clk    (clk),
      .init_n (init_n),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2047:0] m;
      logic [63:0]   r;
      logic [31:0]   cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   bit          reported = 1'b0;
   int          edge_cnt;

   logic [15:0] prog [1024];
   logic [7:0]  mdm  [256];
   logic [7:0]  mreg [8];
   int          mcyc;

   always @(posedge clk or negedge init_n) begin
      if (!init_n) edge_cnt <= 0;
      else if (!done) edge_cnt <= edge_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic logic [15:0] enc_r(input logic [3:0] op, input int d, input int s, input int t);
      return {op, 3'(d), 3'(s), 3'(t), 3'b000};
   endfunction

   function automatic logic [15:0] enc_i(input logic [3:0] op, input int d, input logic [7:0] imm);
      return {op, 3'(d), 1'b0, imm};
   endfunction

   function automatic logic [15:0] enc_b(input logic [3:0] op, input int d, input int s, input int off);
      return {op, 3'(d), 3'(s), 6'(off)};
   endfunction

   // Architectural model: executes the program from the rules of the ISA.
   task automatic model_run();
      int pc;
      logic [15:0] ins;
      logic [7:0] a, b, d, imm;
      int off;
      pc = 0;
      mcyc = 0;
      for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
      for (int step = 0; step < 5000; step++) begin
         ins = prog[pc];
         mcyc++;
         a   = mreg[ins[8:6]];
         b   = mreg[ins[5:3]];
         d   = mreg[ins[11:9]];
         imm = ins[7:0];
         off = int'($signed(ins[5:0]));
         if (ins[15:12] == 4'hF) break;
         case (ins[15:12])
            4'h0: mreg[ins[11:9]] = a + b;
            4'h1: mreg[ins[11:9]] = a - b;
            4'h2: mreg[ins[11:9]] = a & b;
            4'h3: mreg[ins[11:9]] = a | b;
            4'h4: mreg[ins[11:9]] = a ^ b;
            4'h5: mreg[ins[11:9]] = a * 2;
            4'h6: mreg[ins[11:9]] = a / 2;
            4'h7: mreg[ins[11:9]] = {7'b0, ^a};
            4'h8: mreg[ins[11:9]] = imm;
            4'h9: mreg[ins[11:9]] = mdm[a];
            4'hA: mdm[a] = d;
            4'hE: mreg[ins[11:9]] = d + imm;
            default: ;
         endcase
         if (ins[15:12] == 4'hB && d == a)      pc = pc + 1 + off;
         else if (ins[15:12] == 4'hC && d != a) pc = pc + 1 + off;
         else if (ins[15:12] == 4'hD)           pc = int'(ins[9:0]);
         else                                   pc = pc + 1;
         pc = ((pc % 1024) + 1024) % 1024;
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 1024; i++) prog[i] = 16'hF000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      init_n = 1'b0;
      #1;
      chk("done_async_clear", {31'b0, done}, 32'd0);
      for (int i = 0; i < 1024; i++) dut.imem[i] = prog[i];
      @(negedge clk);
      chk("reset_pc", 32'(dut.pc_q), 32'd0);
      for (int i = 0; i < 8; i++) chk("reset_reg", {24'b0, dut.regs_q[i]}, 32'd0);
      @(negedge clk);
   endtask

   task automatic run_prog(input string nm);
      exp_t e;
      do_reset();
      chk("reset_dmem10_kept", {24'b0, dut.dmem[10]}, {24'b0, mdm[10]});
      model_run();
      for (int i = 0; i < 256; i++) e.m[i*8 +: 8] = mdm[i];
      for (int i = 0; i < 8; i++)   e.r[i*8 +: 8] = mreg[i];
      e.cyc = 32'(mcyc);
      exp_q.push_back(e);
      reported = 1'b0;
      init_n = 1'b1;
      for (int c = 0; c < mcyc + 20; c++) begin
         @(negedge clk);
         #1;
         if (reported) break;
      end
      if (!reported) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got done=%0b expected done=1", nm, done);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   // Monitor: consumes one expectation each time the core reports done.
   initial begin
      exp_t e;
      logic [2047:0] mem_act;
      forever begin
         @(negedge clk);
         if (init_n === 1'b1 && done === 1'b1 && !reported) begin
            reported = 1'b1;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 expected no pending program");
            end else begin
               e = exp_q.pop_front();
               chk("cycles_to_done", 32'(edge_cnt), e.cyc);
               for (int i = 0; i < 8; i++)
                  chk($sformatf("reg_r%0d", i), {24'b0, dut.regs_q[i]}, {24'b0, e.r[i*8 +: 8]});
               for (int i = 0; i < 256; i++) mem_act[i*8 +: 8] = dut.dmem[i];
               tests++;
               if (mem_act !== e.m) begin
                  fails++;
                  for (int i = 0; i < 256; i++)
                     if (mem_act[i*8 +: 8] !== e.m[i*8 +: 8]) begin
                        $display("FAIL dmem[%0d]: got %0h expected %0h", i, mem_act[i*8 +: 8], e.m[i*8 +: 8]);
                        break;
                     end
               end
            end
         end
      end
   end

   initial begin
      logic [15:0] ins;
      int          len;
      int          op;
      init_n = 1'b1;
      for (int i = 0; i < 256; i++) begin
         mdm[i] = 8'h00;
         dut.dmem[i] = 8'h00;
      end
      mdm[10] = 8'h77;
      dut.dmem[10] = 8'h77;

      // ALU and store
      clear_prog();
      prog[0] = enc_i(4'h8, 1, 8'hB4);
      prog[1] = enc_i(4'h8, 2, 8'h55);
      prog[2] = enc_r(4'h2, 3, 1, 2);
      prog[3] = enc_i(4'h8, 5, 8'd64);
      prog[4] = enc_b(4'hA, 3, 5, 0);
      prog[5] = 16'hF000;
      run_prog("alu_store");
      chk("alu_store_dmem64", {24'b0, dut.dmem[64]}, 32'h14);
      chk("alu_store_edges", 32'(edge_cnt), 32'd6);

      // LFSR step
      clear_prog();
      prog[0] = enc_i(4'h8, 1, 8'h5A);
      prog[1] = enc_i(4'h8, 2, 8'hB4);
      prog[2] = enc_r(4'h5, 3, 1, 0);
      prog[3] = enc_r(4'h2, 4, 1, 2);
      prog[4] = enc_r(4'h7, 4, 4, 0);
      prog[5] = enc_r(4'h3, 3, 3, 4);
      run_prog("lfsr");
      chk("lfsr_r3", {24'b0, dut.regs_q[3]}, 32'hB5);

      // Modulo-256 wrap
      clear_prog();
      prog[0] = enc_i(4'h8, 1, 8'hFF);
      prog[1] = enc_i(4'h8, 2, 8'h02);
      prog[2] = enc_r(4'h0, 3, 1, 2);
      prog[3] = enc_r(4'h1, 4, 2, 1);
      run_prog("wrap");
      chk("wrap_add", {24'b0, dut.regs_q[3]}, 32'h01);
      chk("wrap_sub", {24'b0, dut.regs_q[4]}, 32'h03);

      // Backward branch loop
      clear_prog();
      prog[0] = enc_i(4'h8, 1, 8'd0);
      prog[1] = enc_i(4'h8, 2, 8'd3);
      prog[2] = enc_i(4'hE, 1, 8'd1);
      prog[3] = enc_b(4'hC, 1, 2, -2);
      run_prog("loop");
      chk("loop_r1", {24'b0, dut.regs_q[1]}, 32'd3);
      chk("loop_edges", 32'(edge_cnt), 32'd9);

      // Rerun with retained data memory: each run increments dmem[0]
      mdm[0] = 8'h05;
      dut.dmem[0] = 8'h05;
      clear_prog();
      prog[0] = enc_b(4'h9, 1, 0, 0);
      prog[1] = enc_i(4'hE, 1, 8'd1);
      prog[2] = enc_b(4'hA, 1, 0, 0);
      prog[3] = enc_i(4'h8, 6, 8'h3C);
      prog[4] = enc_b(4'hB, 6, 6, 2);
      prog[5] = enc_i(4'h8, 6, 8'hEE);
      prog[7] = enc_b(4'hD, 0, 0, 0) | 16'd9;
      prog[9] = 16'hF000;
      run_prog("rerun1");
      chk("rerun1_dmem0", {24'b0, dut.dmem[0]}, 32'h06);
      run_prog("rerun2");
      chk("rerun2_dmem0", {24'b0, dut.dmem[0]}, 32'h07);

      // Abort a non-terminating program with reset
      clear_prog();
      prog[0] = enc_i(4'hE, 1, 8'd1);
      prog[1] = enc_b(4'hD, 0, 0, 0);
      do_reset();
      init_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("spin_not_done", {31'b0, done}, 32'd0);
      init_n = 1'b0;
      #1;
      chk("abort_pc", 32'(dut.pc_q), 32'd0);
      chk("abort_r1", {24'b0, dut.regs_q[1]}, 32'd0);

      // Randomized straight-line programs with forward branches
      for (int t = 0; t < 10; t++) begin
         clear_prog();
         for (int i = 0; i < 256; i++) begin
            mdm[i] = 8'($urandom);
            dut.dmem[i] = mdm[i];
         end
         len = int'($urandom_range(10, 40));
         for (int i = 0; i < len; i++) begin
            op = int'($urandom_range(0, 14));
            if (op == 13) op = 8;
            ins = 16'($urandom);
            ins[15:12] = 4'(op);
            if (op == 11 || op == 12) ins[5:0] = 6'($urandom_range(0, 3));
            prog[i] = ins;
         end
         run_prog($sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 1024, instruction memory words (PC width = log2(IMEM_DEPTH) = 10).
REQ-002 SHALL have parameter DMEM_DEPTH, default 256, data memory bytes (8-bit addresses).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port init_n  input  1  init/reset command; asynchronous, active-low.
REQ-005 SHALL have port done  output  1  high once the program has executed HALT.
REQ-006 SHALL contain instruction memory array imem[IMEM_DEPTH] of 16-bit words, hierarchically loadable (dut.imem, $readmemb), read-only to the core.
REQ-007 SHALL contain data memory array dmem[DMEM_DEPTH] of 8-bit bytes, hierarchically readable and writable (dut.dmem).

Function
REQ-008 SHALL execute one instruction per clock (single-cycle): fetch imem[pc], decode, execute, write back at the rising edge.
REQ-009 SHALL provide eight 8-bit registers r0-r7, all writable, no hardwired zero.
REQ-010 SHALL decode fields: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm8=[7:0], off6=[5:0] signed, addr=[9:0].
REQ-011 SHALL implement ALU ops, 8-bit, carries/borrows discarded (mod 256): 0 ADD rd=rs+rt; 1 SUB rd=rs-rt; 2 AND; 3 OR; 4 XOR; 5 SHL rd=rs<<1, LSB 0; 6 SHR rd=rs>>1, MSB 0; 7 PAR rd={7'b0, XOR-reduce rs}.
REQ-012 SHALL implement 8 LDI rd=imm8; E ADDI rd=rd+imm8 (mod 256).
REQ-013 SHALL implement 9 LD rd=dmem[rs] (combinational read) and A ST dmem[rs]=rd (written at rising edge).
REQ-014 SHALL implement B BEQ / C BNE comparing rd with rs; taken: pc=pc+1+sext(off6); not taken: pc=pc+1.
REQ-015 SHALL implement D JMP pc=addr.
REQ-016 SHALL implement F HALT: pc holds, done=1 from the next rising edge; no further register or dmem writes until reset.
REQ-017 All other instructions SHALL set pc=pc+1; pc wraps modulo IMEM_DEPTH.
REQ-018 A write to register rd and a read of the same register in one instruction SHALL use the old value.
REQ-019 Software memory map SHALL be: dmem[0:40] plaintext, [41] preamble length, [42] LFSR tap pattern, [43] LFSR seed, [64:127] ciphertext, [128:255] program scratch/constants (e.g. tap LUT at 140-147); hardware imposes no restriction.

Reset
REQ-020 While init_n=0 (asynchronous): pc=0, r0-r7=0, done=0, no dmem write.
REQ-021 Reset SHALL NOT clear imem or dmem; contents persist across runs.
REQ-022 On init_n release, execution SHALL begin at imem[0] at the first rising edge; reset asserted mid-program or after done SHALL abort and restart.
REQ-023 done SHALL stay high after HALT until init_n=0.

Verification
REQ-024 Reset: dmem[10]=0x77 preloaded, init_n=0 -> done=0, pc=0, regs 0, dmem[10] still 0x77.
REQ-025 ALU/store: LDI r1,0xB4; LDI r2,0x55; AND r3,r1,r2; LDI r5,64; ST r3,[r5]; HALT -> dmem[64]=0x14, done rises after the 6th edge.
REQ-026 LFSR step: r1=0x5A, r2=0xB4; SHL r3,r1; AND r4,r1,r2; PAR r4,r4; OR r3,r3,r4 -> r3=0xB5.
REQ-027 Wrap: LDI r1,0xFF; LDI r2,0x02; ADD r3,r1,r2 -> 0x01; SUB r4,r2,r1 -> 0x03.
REQ-028 Loop: r1=0, r2=3; ADDI r1,1; BNE r1,r2,-2; HALT -> r1=3, branch taken twice, then HALT.
REQ-029 Rerun: after done, init_n low 20 ns then high -> done falls immediately, program restarts from pc 0 using retained dmem, done reasserts at HALT.
